// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single port of the 256 x 8 byte-addressed Memory between
// instruction fetch (port I, always word reads) and load/store (port D).
// One transaction at a time: IDLE -> WRITE | READ | RESP -> IDLE, one response per request.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_req_*              fetch request (valid/ready/addr)
//   i_resp_*             fetch response pulse (valid/data/err)
//   d_req_*              load/store request (valid/ready/addr/wdata/size/we)
//   d_resp_*             load/store response pulse (valid/data/err)
//   memory_*             registered Memory interface; memory_out is the read data back
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both ports request.
// Left undefined, D always wins over I.
module mem_port_arbiter #(
  parameter int unsigned ADDR_LIMIT   = 256,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [1:0]  d_req_size,
  input  logic        d_req_we,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err,
  output logic [31:0] memory_address,
  output logic [31:0] memory_in,
  output logic [1:0]  memory_size,
  output logic        memory_write_enable,
  input  logic [31:0] memory_out
);

  localparam int unsigned CntW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(READ_LATENCY);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            port_i_q, port_i_d;   // owner of the transaction in flight is port I
  logic [1:0]      size_q, size_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_in_q, mem_in_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic            mem_we_q, mem_we_d;

  logic        grant_d, grant_i, hs;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_we;
  logic [32:0] req_last;
  logic        req_err;
  logic [31:0] rd_mask;

  // Grant selection
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_i_q;  // last handshake went to I; reset value makes D win the first tie

  always_ff @(posedge clk) begin
    if (rst) begin
      last_i_q <= 1'b1;
    end else if (hs) begin
      last_i_q <= grant_i;
    end
  end

  assign grant_d = d_req_valid && (!i_req_valid || last_i_q);
  assign grant_i = i_req_valid && (!d_req_valid || !last_i_q);
`else
  assign grant_d = d_req_valid;
  assign grant_i = i_req_valid && !d_req_valid;
`endif

  assign hs       = (state_q == StIdle) && !rst && (grant_d || grant_i);
  assign req_addr = grant_i ? i_req_addr : d_req_addr;
  assign req_size = grant_i ? 2'b10 : d_req_size;
  assign req_we   = grant_i ? 1'b0 : d_req_we;

  // Range check on the last byte touched; 33 bits so addresses near 2^32 cannot wrap.
  always_comb begin
    unique case (req_size)
      2'b00:   req_last = {1'b0, req_addr};
      2'b01:   req_last = {1'b0, req_addr} + 33'd1;
      default: req_last = {1'b0, req_addr} + 33'd3;
    endcase
    req_err = (req_size == 2'b11) || (req_last >= 33'(ADDR_LIMIT));
  end

  // Zero-extension of load data by access size
  always_comb begin
    unique case (size_q)
      2'b00:   rd_mask = 32'h0000_00ff;
      2'b01:   rd_mask = 32'h0000_ffff;
      default: rd_mask = 32'hffff_ffff;
    endcase
  end

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      port_i_q    <= 1'b0;
      size_q      <= 2'b00;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_in_q    <= '0;
      mem_size_q  <= 2'b00;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      port_i_q    <= port_i_d;
      size_q      <= size_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_in_q    <= mem_in_d;
      mem_size_q  <= mem_size_d;
      mem_we_q    <= mem_we_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          if (req_err)     state_d = StResp;
          else if (req_we) state_d = StWrite;
          else             state_d = StRead;
        end
      end
      StWrite: state_d = StResp;
      StRead:  if (cnt_q == LastCnt) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values; memory outputs are loaded here so they come out registered.
  always_comb begin
    cnt_d       = cnt_q;
    port_i_d    = port_i_q;
    size_d      = size_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_in_d    = mem_in_q;
    mem_size_d  = mem_size_q;
    mem_we_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          port_i_d    = grant_i;
          size_d      = req_size;
          cnt_d       = '0;
          resp_data_d = '0;
          resp_err_d  = req_err;
          // Rejected requests leave the memory port untouched.
          if (!req_err) begin
            mem_addr_d = req_addr;
            mem_size_d = req_size;
            mem_we_d   = req_we;
            mem_in_d   = req_we ? d_req_wdata : '0;
          end
        end
      end
      StRead: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) resp_data_d = memory_out & rd_mask;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    i_req_ready         = (state_q == StIdle) && !rst && grant_i;
    d_req_ready         = (state_q == StIdle) && !rst && grant_d;
    i_resp_valid        = (state_q == StResp) && port_i_q;
    d_resp_valid        = (state_q == StResp) && !port_i_q;
    i_resp_data         = i_resp_valid ? resp_data_q : '0;
    i_resp_err          = i_resp_valid && resp_err_q;
    d_resp_data         = d_resp_valid ? resp_data_q : '0;
    d_resp_err          = d_resp_valid && resp_err_q;
    memory_address      = mem_addr_q;
    memory_in           = mem_in_q;
    memory_size         = mem_size_q;
    memory_write_enable = mem_we_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int Limit   = 256;
  localparam int ReadLat = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        i_resp_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic [31:0] d_req_addr = '0;
  logic [31:0] d_req_wdata = '0;
  logic [1:0]  d_req_size = 2'b00;
  logic        d_req_we = 1'b0;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        d_resp_err;
  logic [31:0] memory_address;
  logic [31:0] memory_in;
  logic [1:0]  memory_size;
  logic        memory_write_enable;
  logic [31:0] memory_out = '0;

  mem_port_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_req_valid         (i_req_valid),
    .i_req_ready         (i_req_ready),
    .i_req_addr          (i_req_addr),
    .i_resp_valid        (i_resp_valid),
    .i_resp_data         (i_resp_data),
    .i_resp_err          (i_resp_err),
    .d_req_valid         (d_req_valid),
    .d_req_ready         (d_req_ready),
    .d_req_addr          (d_req_addr),
    .d_req_wdata         (d_req_wdata),
    .d_req_size          (d_req_size),
    .d_req_we            (d_req_we),
    .d_resp_valid        (d_resp_valid),
    .d_resp_data         (d_resp_data),
    .d_resp_err          (d_resp_err),
    .memory_address      (memory_address),
    .memory_in           (memory_in),
    .memory_size         (memory_size),
    .memory_write_enable (memory_write_enable),
    .memory_out          (memory_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: observed %0h (cycle %0d)", name, act, cyc);
  endtask

  // Memory block model: byte writes in the write-enable cycle, two-edge registered read.
  byte unsigned mem_arr[Limit];
  logic [31:0]  rd_stage = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (longint'(a) + i < Limit) w[8*i +: 8] = mem_arr[int'(a[7:0]) + i];
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (memory_write_enable) begin
      for (int i = 0; i < 4; i++) begin
        if ((memory_size == 2'b10 || i < int'(memory_size) + 1) && longint'(memory_address) + i < Limit)
          mem_arr[int'(memory_address[7:0]) + i] <= memory_in[8*i +: 8];
      end
    end
    rd_stage   <= mem_word(memory_address);
    memory_out <= rd_stage;
  end

  // Reference model: a flat byte array updated in handshake order.
  byte unsigned ref_mem[Limit];

  function automatic void ref_access(input bit port_i, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [1:0] size,
                                     input bit we, output logic [31:0] data, output bit err,
                                     output int lat);
    logic [1:0] sz;
    bit         w;
    int         n;
    sz   = port_i ? 2'b10 : size;
    w    = port_i ? 1'b0 : we;
    n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    data = '0;
    err  = (sz == 2'b11) || (longint'(addr) + n > Limit);
    if (err) begin
      lat = 1;
    end else if (w) begin
      for (int i = 0; i < n; i++) ref_mem[int'(addr[7:0]) + i] = wdata[8*i +: 8];
      lat = 2;
    end else begin
      for (int i = 0; i < n; i++) data[8*i +: 8] = ref_mem[int'(addr[7:0]) + i];
      lat = ReadLat + 2;
    end
  endfunction

  typedef struct {
    bit          port_i;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   we_q[$];
  bit   grant_log[$];

  // Monitor: every response pulse and every write strobe must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (memory_write_enable) begin
        if (we_q.size() == 0) flag("unexpected_write", 64'(memory_address));
        else check("write_cycle", 64'(cyc), 64'(we_q.pop_front()));
      end
      if (i_resp_valid && d_resp_valid) begin
        flag("dual_resp", 64'(cyc));
      end else if (i_resp_valid || d_resp_valid) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_resp", {32'(i_resp_valid), 32'(d_resp_valid)});
        end else begin
          e = exp_q.pop_front();
          check("resp_port", 64'(i_resp_valid), 64'(e.port_i));
          check("resp_cycle", 64'(cyc), 64'(e.cyc));
          if (e.port_i) begin
            check("i_resp_data", 64'(i_resp_data), 64'(e.data));
            check("i_resp_err", 64'(i_resp_err), 64'(e.err));
            check("d_resp_quiet", {d_resp_data, 31'd0, d_resp_err}, 64'd0);
          end else begin
            check("d_resp_data", 64'(d_resp_data), 64'(e.data));
            check("d_resp_err", 64'(d_resp_err), 64'(e.err));
            check("i_resp_quiet", {i_resp_data, 31'd0, i_resp_err}, 64'd0);
          end
        end
      end
    end
  end

  // Present one request, wait for its handshake, record the expectation.
  // Called and returns at posedge+1; hold keeps valid high for a follow-on request.
  task automatic issue(input bit port_i, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input bit we, input bit push, input bit hold,
                       output int hs_cyc);
    exp_t e;
    int   lat;
    bit   rdy;
    if (port_i) begin
      i_req_valid = 1'b1;
      i_req_addr  = addr;
    end else begin
      d_req_valid = 1'b1;
      d_req_addr  = addr;
      d_req_wdata = wdata;
      d_req_size  = size;
      d_req_we    = we;
    end
    hs_cyc = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      rdy = port_i ? i_req_ready : d_req_ready;
      if (rdy) begin
        hs_cyc = cyc;
        break;
      end
    end
    if (hs_cyc < 0) begin
      flag(port_i ? "i_handshake_timeout" : "d_handshake_timeout", 64'(addr));
      hold = 1'b0;
    end else begin
      grant_log.push_back(port_i);
      e.port_i = port_i;
      ref_access(port_i, addr, wdata, size, we, e.data, e.err, lat);
      e.cyc = hs_cyc + lat;
      if (push) begin
        exp_q.push_back(e);
        if (!port_i && we && !e.err) we_q.push_back(hs_cyc + 1);
      end
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      if (port_i) i_req_valid = 1'b0;
      else        d_req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 32; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      flag("drain_timeout", 64'(exp_q.size()));
      exp_q.delete();
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_addr"}, 64'(memory_address), 64'd0);
    check({tag, "_mem_in"}, 64'(memory_in), 64'd0);
    check({tag, "_ctl"}, {56'd0, memory_size, memory_write_enable, i_resp_valid, i_resp_err,
                          d_resp_valid, d_resp_err, i_req_ready | d_req_ready}, 64'd0);
    check({tag, "_resp_data"}, {i_resp_data, d_resp_data}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          hs;
    int          s;
    bit          p;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    bit          w;

    for (int i = 0; i < Limit; i++) ref_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;

    // Both ports valid every cycle: four D ops against four I fetches
    fork
      begin
        for (int j = 0; j < 4; j++) begin
          int h;
          issue(1'b0, 32'h80 + 32'(4 * j), $urandom, 2'b10, 1'(j % 2 == 0), 1'b1, j < 3, h);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          int h;
          issue(1'b1, 32'h80 + 32'(4 * j), '0, 2'b10, 1'b0, 1'b1, j < 3, h);
        end
      end
    join
    wait_drain();
    check("grant_count", 64'(grant_log.size()), 64'd8);
    for (int j = 0; j < grant_log.size() && j < 8; j++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check("grant_order_rr", 64'(grant_log[j]), 64'(j % 2));
`else
      check("grant_order_fixed", 64'(grant_log[j]), 64'(j >= 4));
`endif
    end

    // Word store then load back
    issue(1'b0, 32'h10, 32'hdead_beef, 2'b10, 1'b1, 1'b1, 1'b0, hs);
    wait_drain();
    issue(1'b0, 32'h10, '0, 2'b10, 1'b0, 1'b1, 1'b0, hs);
    wait_drain();

    // Byte store over a word, then half and byte loads
    issue(1'b0, 32'h20, 32'h1122_3344, 2'b10, 1'b1, 1'b1, 1'b0, hs);
    wait_drain();
    issue(1'b0, 32'h20, 32'h0000_00ab, 2'b00, 1'b1, 1'b1, 1'b0, hs);
    wait_drain();
    issue(1'b0, 32'h20, '0, 2'b01, 1'b0, 1'b1, 1'b0, hs);
    wait_drain();
    issue(1'b0, 32'h21, '0, 2'b00, 1'b0, 1'b1, 1'b0, hs);
    wait_drain();

    // Rejected requests: illegal size, word past the end, half store on the last byte
    issue(1'b0, 32'h30, 32'h5555_5555, 2'b11, 1'b1, 1'b1, 1'b0, hs);
    wait_drain();
    issue(1'b0, 32'hfe, '0, 2'b10, 1'b0, 1'b1, 1'b0, hs);
    wait_drain();
    issue(1'b0, 32'hff, 32'h0000_7777, 2'b01, 1'b1, 1'b1, 1'b0, hs);
    wait_drain();
    issue(1'b1, 32'h0000_0100, '0, 2'b10, 1'b0, 1'b1, 1'b0, hs);
    wait_drain();

    // Lone fetch: ready in the first cycle, address held through READ
    s = cyc;
    issue(1'b1, 32'h40, '0, 2'b10, 1'b0, 1'b1, 1'b0, hs);
    check("fetch_ready_same_cycle", 64'(hs), 64'(s));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fetch_addr_hold", {30'd0, memory_size, memory_address}, {30'd0, 2'b10, 32'h40});
    end
    @(posedge clk);
    #1;
    wait_drain();

    // Reset during a fetch READ aborts it without a response
    issue(1'b1, 32'h44, '0, 2'b10, 1'b0, 1'b0, 1'b0, hs);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    repeat (6) @(posedge clk);
    #1;
    issue(1'b0, 32'h44, 32'hcafe_f00d, 2'b10, 1'b1, 1'b1, 1'b0, hs);
    wait_drain();
    issue(1'b1, 32'h44, '0, 2'b10, 1'b0, 1'b1, 1'b0, hs);
    wait_drain();

    // Randomized traffic, mostly in range with some edge and illegal cases
    for (int j = 0; j < 40; j++) begin
      p  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(240, 259))
                                       : 32'($urandom_range(0, 31));
      wd = $urandom;
      sz = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      issue(p, a, wd, sz, w, 1'b1, 1'b0, hs);
      wait_drain();
    end

    repeat (4) @(posedge clk);
    check("pending_writes", 64'(we_q.size()), 64'd0);
    check("pending_resps", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed Memory block (256 x 8, sizes byte/half/word).
- Shares the single memory port between instruction fetch (port I) and load/store (port D).
- Holds the address stable for the memory's two-edge registered read path, enforces write/read exclusivity and returns one response per accepted request.

Parameters:
- ADDR_LIMIT, 256: number of valid byte addresses. Any access touching a byte at or above ADDR_LIMIT is rejected.
- READ_LATENCY, 2: clock edges the memory needs with the address held and write_enable low before memory_out is valid.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- i_req_valid, in, 1: fetch request valid.
- i_req_ready, out, 1: fetch request accepted this cycle.
- i_req_addr, in, 32: fetch byte address. Fetch is always a word read.
- i_resp_valid, out, 1: fetch response pulse.
- i_resp_data, out, 32: fetch read data.
- i_resp_err, out, 1: fetch address out of range.
- d_req_valid, in, 1: data request valid.
- d_req_ready, out, 1: data request accepted this cycle.
- d_req_addr, in, 32: data byte address.
- d_req_wdata, in, 32: store data, little-endian in low bytes.
- d_req_size, in, 2: 00 byte, 01 half, 10 word, 11 illegal.
- d_req_we, in, 1: 1 store, 0 load.
- d_resp_valid, out, 1: data response pulse (loads and stores).
- d_resp_data, out, 32: load data, zero-extended; 0 for stores.
- d_resp_err, out, 1: illegal size or out-of-range address.
- memory_address, out, 32: to Memory.
- memory_in, out, 32: to Memory.
- memory_size, out, 2: to Memory.
- memory_write_enable, out, 1: to Memory.
- memory_out, in, 32: from Memory.

Behaviour:
- Reset: all outputs 0; state IDLE; latency counter 0; round-robin pointer favours D.
- Reset asserted mid-operation aborts the transaction. No response is issued; memory_write_enable drops on the next edge.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - x_req_ready is combinational and high only for the granted port, and only when that port's valid is high.
  - Default grant is fixed priority, D over I.
  - Handshake = valid && ready. On handshake, latch port id, addr, wdata, size and we.
  - Range check: byte count n = 1/2/4 by size; error if size==11 or addr+n-1 >= ADDR_LIMIT.
  - Error: go to RESP with err=1, data=0, no memory access.
  - Otherwise go to WRITE (store) or READ (load or fetch).
- All memory_* outputs are registered. memory_write_enable is high only in WRITE. memory_address and memory_size are held constant for the whole of READ.
- WRITE:
  - Exactly one cycle with memory_write_enable=1 and latched address/data/size, then go to RESP.
  - Store: handshake at cycle T, resp_valid at T+2.
- READ:
  - memory_write_enable=0; counter runs from 0 to READ_LATENCY.
  - On the last count, capture memory_out into the response register and go to RESP.
  - Load/fetch: handshake at T, resp_valid at T+READ_LATENCY+2 (T+4 by default).
- RESP:
  - Exactly one cycle of resp_valid to the owning port, with data/err from the registers. The other port's resp outputs stay 0.
  - Return to IDLE.
  - A new request can be accepted in the IDLE cycle after RESP, so there is one idle-cycle bubble per access.
- Requesters have no response back-pressure; resp_valid is a single-cycle pulse.
- Requests arriving outside IDLE see ready=0 and must hold valid plus payload stable until accepted.
- Request payload changes after handshake have no effect.
- memory_address upper bits are passed through unmodified; the range check guarantees in-range values.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both ports request in IDLE, grant goes to the port not served last. The pointer updates on every handshake. A lone requester is always granted.
- Undefined: fixed priority, D always wins and I can starve. The pointer logic is absent.

Test Plan:
- Store word 0xDEADBEEF @0x10, handshake T -> write_enable=1 only at T+1; d_resp_valid at T+2, err=0. Then load word @0x10 -> d_resp_data=0xDEADBEEF at handshake+4.
- Store byte 0xAB @0x20 over word 0x11223344 -> load half @0x20 returns 0x000033AB; load byte @0x21 returns 0x00000033.
- Both valid every cycle, macro off -> D granted each time, I never ready. Macro on -> grants alternate D,I,D,I and each port gets correct data.
- d_req_size=11, and separately word load @0xFE -> d_resp_err=1, data=0, memory_write_enable never asserted, resp at handshake+1.
- Fetch @0x40 with d_req_valid low -> i_req_ready same cycle, memory_address=0x40 held 3 cycles, i_resp_valid at handshake+4, d_resp_valid stays 0.
- rst pulsed during READ of a fetch -> no i_resp_valid, all outputs 0 next cycle. A following store succeeds normally.
